byte_encode_stream: RTL and testbench

Sequential, runtime-configurable successor to the combinational ML-KEM ByteEncode_d packer. It accepts one 256-coefficient polynomial as a valid/ready coefficient stream, packs the low d bits of each coefficient little-endian into a bit accumulator, and emits the 32·d-byte result as OUT_BYTES-wide words over a valid/ready output. It sits between the NTT/compress datapath and the key/ciphertext serialiser. d is selected per polynomial instead of by elaboration parameter.

---
 rtl/byte_encode_stream.sv | 140 ++++++++++++++
 tb/tb_byte_encode_stream.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_encode_stream.sv
// byte_encode_stream
// Streaming ML-KEM ByteEncode_d packer with per-polynomial d. Takes 256
// coefficients over a valid/ready stream. The low d bits of each coefficient
// are packed little-endian into a bit accumulator. The packed result
// (32*d bytes) is emitted as 8*OUT_BYTES-bit words over a valid/ready output.
//
// Ports
//   clk_i, rst_ni             clock, synchronous active-low reset
//   start_i, d_i              start a polynomial with d bits per coefficient
//   busy_o, done_o, err_o     busy flag, completion pulse, illegal-d pulse
//   coef_valid_i/ready_o/i    coefficient input stream
//   out_valid_o/ready_i       packed word output handshake
//   out_data_o, out_last_o    packed word (byte lane 0 lowest), last-word flag
module byte_encode_stream #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_BYTES = 4,
   parameter int D_MAX     = 12
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [3:0]             d_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   input  logic                   coef_valid_i,
   output logic                   coef_ready_o,
   input  logic [IN_WIDTH-1:0]    coef_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [8*OUT_BYTES-1:0] out_data_o,
   output logic                   out_last_o
);

   localparam int W     = 8 * OUT_BYTES;
   localparam int ACC_W = W + D_MAX - 1;
   localparam int CNT_W = $clog2(W + D_MAX);
   localparam int WC_W  = $clog2(32 * D_MAX / OUT_BYTES + 1);
   localparam int OB_SH = $clog2(OUT_BYTES);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ENCODE = 1'b1;

   logic [0:0]          state;
   logic [3:0]          d;
   logic [8:0]          coef_cnt;
   logic [WC_W-1:0]     word_cnt;
   logic [WC_W-1:0]     words_last;
   logic [ACC_W-1:0]    acc;
   logic [CNT_W-1:0]    acc_cnt;
   logic                done;
   logic                err;

   logic                d_legal;
   logic                full;
   logic                pop;
   logic                accept;
   logic                room;
   logic [CNT_W-1:0]    cnt_pop;
   logic [CNT_W-1:0]    cnt_base;
   logic [ACC_W-1:0]    acc_base;
   logic [IN_WIDTH-1:0] mask;
   logic [ACC_W-1:0]    ins;

   always_comb begin
      d_legal    = (d_i != 4'd0) && (d_i <= 4'(D_MAX));
      full       = acc_cnt >= CNT_W'(W);
      pop        = full & out_ready_i;
      cnt_pop    = acc_cnt - CNT_W'(W);
      // An insert is only allowed when the post-pop fill is below one word,
      // so the new coefficient always fits. At the default widths this is
      // the same as (not full or popping).
      room       = !full || (out_ready_i && (cnt_pop < CNT_W'(W)));
      // Shift first, then insert at the post-shift fill level.
      cnt_base   = pop ? cnt_pop : acc_cnt;
      acc_base   = pop ? (acc >> W) : acc;
      mask       = ~({IN_WIDTH{1'b1}} << d);
      ins        = ACC_W'(coef_i & mask) << cnt_base;
      words_last = WC_W'(((int'(d) << 5) >> OB_SH) - 1);
      accept     = coef_valid_i & coef_ready_o;
   end

   assign busy_o       = (state == ENCODE);
   assign done_o       = done;
   assign err_o        = err;
   assign coef_ready_o = busy_o & ~coef_cnt[8] & room;
   assign out_valid_o  = full;
   assign out_data_o   = acc[W-1:0];
   assign out_last_o   = busy_o & (word_cnt == words_last);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= IDLE;
         d        <= '0;
         coef_cnt <= '0;
         word_cnt <= '0;
         acc      <= '0;
         acc_cnt  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (d_legal) begin
                     state    <= ENCODE;
                     d        <= d_i;
                     coef_cnt <= '0;
                     word_cnt <= '0;
                     acc      <= '0;
                     acc_cnt  <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            default: begin
               if (accept) begin
                  acc      <= acc_base | ins;
                  acc_cnt  <= cnt_base + CNT_W'(d);
                  coef_cnt <= coef_cnt + 9'd1;
               end else if (pop) begin
                  acc      <= acc_base;
                  acc_cnt  <= cnt_base;
               end
               if (pop) begin
                  word_cnt <= word_cnt + 1'b1;
                  if (word_cnt == words_last) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_byte_encode_stream.sv
// Self-checking bench for byte_encode_stream. The stimulus process pushes
// expected words (built from a flat bit-stream model) into a queue. A negedge
// monitor pops the queue and compares on every output handshake.
module tb_byte_encode_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  d_in = 4'd0;
   logic        busy, done, err;
   logic        coef_valid = 1'b0;
   logic        coef_ready;
   logic [15:0] coef = 16'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_last;

   byte_encode_stream dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .d_i(d_in),
      .busy_o(busy), .done_o(done), .err_o(err),
      .coef_valid_i(coef_valid), .coef_ready_o(coef_ready), .coef_i(coef),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_last_o(out_last)
   );

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] coefs[256];
   int          checks = 0, errors = 0, cyc = 0;
   bit          rdy_rand = 1'b0;
   int          words_seen, done_seen, err_seen, coefs_acc;
   int          last_hs_cyc, c1_cyc, c256_cyc;
   logic [31:0] first_word, last_word;
   bit          stall_prev = 1'b0;
   logic [32:0] prev_out;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'({out_last, out_data}), 64'(prev_out));
         end
         stall_prev = out_valid && !out_ready;
         prev_out   = {out_last, out_data};
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0h expected none", out_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("word_data", 64'(out_data), 64'(e.data));
               chk("word_last", 64'(out_last), 64'(e.last));
            end
            if (words_seen == 0) first_word = out_data;
            last_word   = out_data;
            words_seen++;
            last_hs_cyc = cyc;
         end
         if (coefs_acc >= 256) chk("ready_after_256", 64'(coef_ready), 64'd0);
         if (coef_valid && coef_ready) begin
            coefs_acc++;
            if (coefs_acc == 1)   c1_cyc   = cyc;
            if (coefs_acc == 256) c256_cyc = cyc;
         end
         if (done) begin
            done_seen++;
            chk("done_latency", 64'(cyc), 64'(last_hs_cyc + 1));
         end
         if (err) err_seen++;
      end
   end

   // Runs one polynomial from coefs[]. abort_at >= 0 stops feeding after that
   // many coefficients and returns without draining.
   task automatic run_poly(input int dv, input bit rr, input int abort_at, input int mid_start_at);
      bit bits[$];
      int nwords, i, t;
      bit acc_now;
      rdy_rand   = rr;
      words_seen = 0;
      done_seen  = 0;
      coefs_acc  = 0;
      for (int c = 0; c < 256; c++)
         for (int j = 0; j < dv; j++) bits.push_back(coefs[c][j]);
      nwords = 256 * dv / 32;
      for (int w = 0; w < nwords; w++) begin
         exp_t e;
         e.data = '0;
         for (int b = 0; b < 32; b++) e.data[b] = bits[w*32 + b];
         e.last = (w == nwords - 1);
         exp_q.push_back(e);
      end
      start = 1'b1;
      d_in  = 4'(dv);
      @(posedge clk);
      #1;
      start = 1'b0;
      i = 0;
      t = 0;
      while (i < 256 && t < 5000) begin
         if (abort_at >= 0 && i == abort_at) break;
         coef_valid = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
         coef       = coefs[i];
         start      = (i == mid_start_at);
         d_in       = 4'd4;
         @(negedge clk);
         acc_now = coef_valid && coef_ready;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (acc_now) i++;
         t++;
      end
      coef_valid = 1'b0;
      if (abort_at >= 0) begin
         rdy_rand = 1'b0;
         return;
      end
      chk("coef_feed_complete", 64'(i), 64'd256);
      t = 0;
      while ((exp_q.size() != 0 || done_seen == 0) && t < 3000) begin
         @(posedge clk);
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      chk("done_count", 64'(done_seen), 64'd1);
      chk("word_count", 64'(words_seen), 64'(8 * dv));
      if (!rr) begin
         chk("throughput", 64'(c256_cyc - c1_cyc), 64'd255);
         chk("drain_latency", 64'(last_hs_cyc), 64'(c256_cyc + 1));
      end
      rdy_rand = 1'b0;
   endtask

   task automatic bad_start(input logic [3:0] dv);
      err_seen = 0;
      start = 1'b1;
      d_in  = dv;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("err_busy_low", 64'(busy), 64'd0);
      end
      @(posedge clk);
      #1;
      chk("err_pulse_count", 64'(err_seen), 64'd1);
   endtask

   initial begin
      int sweep[4];
      sweep = '{4, 5, 10, 11};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({busy, done, err, coef_ready, out_valid, out_last, out_data}), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 256; i++) coefs[i] = 16'(i % 2);
      run_poly(1, 1'b0, -1, -1);
      chk("d1_first", 64'(first_word), 64'hAAAAAAAA);
      chk("d1_last", 64'(last_word), 64'hAAAAAAAA);

      for (int i = 0; i < 256; i++) coefs[i] = 16'(i);
      run_poly(8, 1'b0, -1, -1);
      chk("d8_first", 64'(first_word), 64'h03020100);
      chk("d8_last", 64'(last_word), 64'hFFFEFDFC);
      for (int i = 0; i < 256; i++) coefs[i] = 16'(16'h1200 + i);
      run_poly(8, 1'b0, -1, -1);
      chk("d8_upper_ignored", 64'(first_word), 64'h03020100);

      for (int i = 0; i < 256; i++) coefs[i] = 16'(i % 3329);
      run_poly(12, 1'b0, -1, -1);
      chk("d12_first", 64'(first_word), 64'h02001000);
      for (int i = 0; i < 256; i++) coefs[i] = 16'($urandom_range(0, 3328));
      run_poly(12, 1'b1, -1, -1);

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 256; i++) coefs[i] = 16'($urandom);
         run_poly(sweep[k], k[0], -1, (k == 2) ? 50 : -1);
      end

      bad_start(4'd0);
      bad_start(4'd13);

      for (int i = 0; i < 256; i++) coefs[i] = 16'($urandom_range(0, 3328));
      run_poly(12, 1'b0, 100, -1);
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_outputs", 64'({busy, done, err, coef_ready, out_valid, out_last, out_data}), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_seen), 64'd0);
      for (int i = 0; i < 256; i++) coefs[i] = 16'(i);
      run_poly(8, 1'b0, -1, -1);
      chk("after_abort_first", 64'(first_word), 64'h03020100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
